// File: rtl/ddr3_cpu_port_arb.sv
// N-port CPU front end for the DDR3 controller: round-robin request arbitration plus in-order read-tag return steering.
// Optional build macro DDR3_ARB_PRIO_EN gives port 0 strict priority over a round-robin of the remaining ports.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no request registered; pick the next eligible port
// ISSUE | request held on the controller path until CMD_RDY accepts it
module ddr3_cpu_port_arb #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int Q_DEPTH   = 4,
    localparam int DM_W     = DATA_W / 8
) (
    input  logic                      CPU_CLK,
    input  logic                      RESET_N,
    input  logic [NUM_PORTS-1:0]      P_ADDR_VALID,
    input  logic [NUM_PORTS-1:0]      P_WE_N,
    input  logic [NUM_PORTS*ADDR_W-1:0] P_ADDR,
    input  logic [NUM_PORTS*DATA_W-1:0] P_WR_DATA,
    input  logic [NUM_PORTS*DM_W-1:0] P_DM,
    output logic [NUM_PORTS-1:0]      P_GRANT,
    output logic [NUM_PORTS-1:0]      P_RD_DATA_VALID,
    output logic [DATA_W-1:0]         P_RD_DATA,
    output logic                      ADDR_VALID,
    output logic                      WE_N,
    output logic [ADDR_W-1:0]         ADDR,
    output logic [DATA_W-1:0]         WR_DATA,
    output logic [DM_W-1:0]           DM,
    input  logic                      CMD_RDY,
    input  logic                      RD_DATA_VALID,
    input  logic [DATA_W-1:0]         RD_DATA,
    output logic                      TAG_FULL,
    output logic                      RET_ERR
);

    localparam int PW = $clog2(NUM_PORTS);
    localparam int QW = $clog2(Q_DEPTH);
    localparam int CW = QW + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [PW-1:0]        ptr;
    logic [PW-1:0]        win;
    logic [PW-1:0]        win_inc;
    logic [PW-1:0]        pick;
    logic                 pick_vld;
    logic [NUM_PORTS-1:0] elig;
    logic                 accept;
    logic                 push;
    logic                 pop;
    logic [NUM_PORTS-1:0] ret_hot;
    logic [PW-1:0]        tag_mem [Q_DEPTH];
    logic [QW-1:0]        wr_ptr;
    logic [QW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic [CW-1:0]        count_nxt;

    // Reads are only blocked by a full tag queue; writes never need a tag.
    always_comb begin
        int idx;
        idx      = 0;
        elig     = '0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            elig[i] = P_ADDR_VALID[i] && (!P_WE_N[i] || !TAG_FULL);
        end
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_PORTS;
`ifdef DDR3_ARB_PRIO_EN
            if (idx != 0 && elig[idx]) begin
`else
            if (elig[idx]) begin
`endif
                pick     = PW'(idx);
                pick_vld = 1'b1;
            end
        end
`ifdef DDR3_ARB_PRIO_EN
        if (elig[0]) begin
            pick     = '0;
            pick_vld = 1'b1;
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld) state_nxt = ISSUE;
            ISSUE:   if (CMD_RDY) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CPU_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign ADDR_VALID = (state == ISSUE);
    assign accept     = (state == ISSUE) && CMD_RDY;
    assign push       = accept && WE_N;
    assign pop        = RD_DATA_VALID && (count != '0);
    assign win_inc    = (int'(win) == NUM_PORTS - 1) ? '0 : win + 1'b1;
    assign count_nxt  = count + CW'(push) - CW'(pop);

    always_comb begin
        P_GRANT = '0;
        ret_hot = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            P_GRANT[i] = accept && (int'(win) == i);
            ret_hot[i] = (int'(tag_mem[rd_ptr]) == i);
        end
    end

    always_ff @(posedge CPU_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            win     <= '0;
            WE_N    <= 1'b1;
            ADDR    <= '0;
            WR_DATA <= '0;
            DM      <= '0;
        end else if (state == IDLE && pick_vld) begin
            win     <= pick;
            WE_N    <= P_WE_N[pick];
            ADDR    <= P_ADDR[int'(pick)*ADDR_W +: ADDR_W];
            WR_DATA <= P_WR_DATA[int'(pick)*DATA_W +: DATA_W];
            DM      <= P_DM[int'(pick)*DM_W +: DM_W];
        end
    end

    // With strict priority the pointer only rotates among ports 1..N-1.
    always_ff @(posedge CPU_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ptr <= '0;
        end else if (accept) begin
`ifdef DDR3_ARB_PRIO_EN
            if (win != '0) ptr <= win_inc;
`else
            ptr <= win_inc;
`endif
        end
    end

    always_ff @(posedge CPU_CLK) begin
        if (push) tag_mem[wr_ptr] <= win;
    end

    always_ff @(posedge CPU_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            TAG_FULL        <= 1'b0;
            RET_ERR         <= 1'b0;
            P_RD_DATA_VALID <= '0;
            P_RD_DATA       <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count    <= count_nxt;
            TAG_FULL <= (count_nxt == CW'(Q_DEPTH));
            if (RD_DATA_VALID && count == '0) RET_ERR <= 1'b1;
            P_RD_DATA_VALID <= pop ? ret_hot : '0;
            if (pop) P_RD_DATA <= RD_DATA;
        end
    end

endmodule
